// File: rtl/branch_sequencer.sv
// branch_sequencer: PC/nPC sequencer with single delay slot and branch-likely squash
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le,
  input  logic        id_br_instr,
  input  logic        id_cond,
  input  logic        id_jump,
  input  logic        id_likely,
  input  logic        id_ta_sel,
  input  logic [31:0] id_ta,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        in_delay_slot,
  output logic        if_squash,
  output logic [15:0] taken_count
);
  typedef enum logic [1:0] {RUN, SLOT, SQUASH} state_t;
  state_t state;
  logic take, likely_nt, run_take, run_squash;
  logic [31:0] target;
  assign take = id_jump | (id_br_instr & id_cond);
  assign likely_nt = id_br_instr & id_likely & ~id_cond & ~id_jump;
  assign target = id_ta_sel ? id_ta : rs_val;
  assign run_take = (state == RUN) & take;
  assign run_squash = (state == RUN) & ~take & likely_nt;
  assign in_delay_slot = state == SLOT;
  assign if_squash = state == SQUASH;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      npc <= RESET_PC + 32'd4;
      state <= RUN;
      taken_count <= 16'd0;
    end else if (le) begin
      pc <= npc;
      npc <= run_take ? target : npc + 32'd4;
      taken_count <= taken_count + {15'd0, run_take};
      state <= run_take ? SLOT : run_squash ? SQUASH : RUN;
    end
  end
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed self-checking bench for branch_sequencer
module tb_branch_sequencer;
  logic clk = 0, reset = 0, le = 0;
  logic id_br_instr = 0, id_cond = 0, id_jump = 0, id_likely = 0, id_ta_sel = 0;
  logic [31:0] id_ta = 0, rs_val = 0, pc, npc;
  logic in_delay_slot, if_squash;
  logic [15:0] taken_count;
  int errors = 0, checks = 0;
  branch_sequencer #(.RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .le(le),
    .id_br_instr(id_br_instr), .id_cond(id_cond), .id_jump(id_jump),
    .id_likely(id_likely), .id_ta_sel(id_ta_sel), .id_ta(id_ta), .rs_val(rs_val),
    .pc(pc), .npc(npc), .in_delay_slot(in_delay_slot), .if_squash(if_squash),
    .taken_count(taken_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] pc_e, input logic [31:0] npc_e,
                         input logic ids_e, input logic sq_e, input logic [15:0] tc_e);
    chk({tag, ".pc"}, pc, pc_e);
    chk({tag, ".npc"}, npc, npc_e);
    chk({tag, ".slot"}, {31'd0, in_delay_slot}, {31'd0, ids_e});
    chk({tag, ".squash"}, {31'd0, if_squash}, {31'd0, sq_e});
    chk({tag, ".count"}, {16'd0, taken_count}, {16'd0, tc_e});
  endtask
  task automatic idle();
    {id_br_instr, id_cond, id_jump, id_likely, id_ta_sel} = '0;
    id_ta = 0;
    rs_val = 0;
  endtask
  initial begin
    reset = 1; le = 1;
    step(); chk_all("reset", 32'h100, 32'h104, 0, 0, 0);
    reset = 0;
    step(); chk_all("seq1", 32'h104, 32'h108, 0, 0, 0);
    id_br_instr = 1; id_cond = 1; id_ta_sel = 1; id_ta = 32'h200;
    step(); chk_all("br_taken", 32'h108, 32'h200, 1, 0, 1);
    idle();
    step(); chk_all("br_target", 32'h200, 32'h204, 0, 0, 1);
    id_jump = 1; id_ta_sel = 0; rs_val = 32'h3000; id_ta = 32'h7777; le = 0;
    step(); chk_all("stall1", 32'h200, 32'h204, 0, 0, 1);
    step(); chk_all("stall2", 32'h200, 32'h204, 0, 0, 1);
    le = 1;
    step(); chk_all("jr", 32'h204, 32'h3000, 1, 0, 2);
    idle(); id_jump = 1; id_ta_sel = 1; id_ta = 32'h900;
    step(); chk_all("slot_jump_ignored", 32'h3000, 32'h3004, 0, 0, 2);
    idle();
    step(); chk_all("after_slot", 32'h3004, 32'h3008, 0, 0, 2);
    id_jump = 1; id_ta_sel = 1; id_ta = 32'h3C;
    step(); chk_all("jump_3c", 32'h3008, 32'h3C, 1, 0, 3);
    idle();
    step(); chk_all("at_3c", 32'h3C, 32'h40, 0, 0, 3);
    step(); chk_all("at_40", 32'h40, 32'h44, 0, 0, 3);
    id_br_instr = 1; id_likely = 1; id_cond = 0; id_ta_sel = 1; id_ta = 32'h880;
    step(); chk_all("likely_nt", 32'h44, 32'h48, 0, 1, 3);
    idle(); le = 0;
    step(); chk_all("squash_stall", 32'h44, 32'h48, 0, 1, 3);
    le = 1; id_jump = 1; id_ta_sel = 1; id_ta = 32'h990;
    step(); chk_all("squash_done", 32'h48, 32'h4C, 0, 0, 3);
    idle(); id_br_instr = 1; id_likely = 1; id_cond = 1; id_ta_sel = 1; id_ta = 32'h500;
    step(); chk_all("likely_taken", 32'h4C, 32'h500, 1, 0, 4);
    idle(); reset = 1; le = 0;
    step(); chk_all("reset_mid_slot", 32'h100, 32'h104, 0, 0, 0);
    reset = 0; le = 1; id_cond = 1;
    step(); chk_all("cond_without_br", 32'h104, 32'h108, 0, 0, 0);
    idle(); id_jump = 1; id_ta_sel = 1; id_ta = 32'hFFFF_FFFC;
    step(); chk_all("jump_top", 32'h108, 32'hFFFF_FFFC, 1, 0, 1);
    idle();
    step(); chk_all("wrap", 32'hFFFF_FFFC, 32'h0, 0, 0, 1);
    step(); chk_all("post_wrap", 32'h0, 32'h4, 0, 0, 1);
    id_br_instr = 1; id_likely = 1;
    step(); chk_all("squash_pre_reset", 32'h4, 32'h8, 0, 1, 1);
    idle(); reset = 1;
    step(); chk_all("reset_mid_squash", 32'h100, 32'h104, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter sequencer for the fetch stage. Owns the PC/nPC register pair, applies the single-delay-slot branch rule, picks between the ID-stage target address and the rs register value, and drives squash of the delay-slot instruction for branch-likely instructions that are not taken. Sits between the ID-stage branch condition logic and the instruction-memory address port. It replaces the free-running nPC+4 path with a controlled sequence.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC resets to RESET_PC+4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- le  in  1  load enable; 1 = pipeline advances this edge, 0 = stall (all state held).
- id_br_instr  in  1  ID holds a conditional branch.
- id_cond  in  1  branch condition true (from condition handler); ignored unless id_br_instr.
- id_jump  in  1  ID holds an unconditional jump.
- id_likely  in  1  branch is a "likely" variant; ignored unless id_br_instr.
- id_ta_sel  in  1  1 = target is id_ta, 0 = target is rs_val.
- id_ta  in  32  PC-relative or absolute target computed in ID.
- rs_val  in  32  register rs contents (jump-register target).
- pc  out  32  fetch address.
- npc  out  32  next fetch address.
- in_delay_slot  out  1  instruction being fetched at pc is a taken transfer's delay slot.
- if_squash  out  1  instruction fetched at pc must be converted to a NOP at IF/ID.
- taken_count  out  16  number of taken transfers since reset.

## Operation
- take = id_jump | (id_br_instr & id_cond).
- likely_nt = id_br_instr & id_likely & ~id_cond & ~id_jump.
- target = id_ta_sel ? id_ta : rs_val (full 32 bits, no alignment masking).
- States: RUN, SLOT, SQUASH. Reset state RUN.
- RUN, le=1:
  - take: pc<=npc, npc<=target, state<=SLOT, taken_count<=taken_count+1.
  - else likely_nt: pc<=npc, npc<=npc+4, state<=SQUASH.
  - else: pc<=npc, npc<=npc+4, state stays RUN.
- SLOT, le=1: pc<=npc, npc<=npc+4, state<=RUN. All id_* inputs are ignored, so a branch in a delay slot is never taken and taken_count does not change.
- SQUASH, le=1: same as SLOT (pc<=npc, npc<=npc+4, state<=RUN, id_* ignored).
- Any state, le=0: pc, npc, state and taken_count all hold.
- in_delay_slot = (state==SLOT). if_squash = (state==SQUASH). Both are decoded from state register, glitch-free.
- Arithmetic: npc+4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. taken_count is modulo 2^16, so FFFF+1 = 0000.
- If take and likely_nt are both true, take wins. This cannot happen because likely_nt requires ~id_cond & ~id_jump; it is listed for completeness.

## Timing
- Reset (reset=1 at a rising edge, which overrides le):
  - pc=RESET_PC, npc=RESET_PC+4, state RUN, taken_count=0, in_delay_slot=0, if_squash=0.
- Reset asserted in SLOT or SQUASH aborts the pending delay slot. No squash or slot flag survives.
- Decision latency: id_* inputs are sampled at the same edge that advances pc. The new pc (the delay slot) appears 1 cycle later. target appears on pc 2 advancing edges after the branch was sampled.
- Stall: le=0 freezes the decision. Inputs sampled on a le=0 edge have no effect. ID must hold its inputs until the le=1 edge.
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset/sequential:
  - Stimulus: RESET_PC=0x100, reset 1 cycle, then le=1 and no branches for 3 edges.
  - Required: pc=0x100, 0x104, 0x108, 0x10C; npc always pc+4; flags 0; taken_count 0.
- Taken branch:
  - Stimulus: at pc=0x104 (npc=0x108), id_br_instr=1, id_cond=1, id_ta_sel=1, id_ta=0x200.
  - Required next cycle: pc=0x108, npc=0x200, in_delay_slot=1, taken_count=1.
  - Required cycle after: pc=0x200, npc=0x204, in_delay_slot=0.
- Jump-register with stall:
  - Stimulus: id_jump=1, id_ta_sel=0, rs_val=0x3000, le=0 for 2 edges, then le=1.
  - Required: pc/npc unchanged during the stall; after the le=1 edge, npc=0x3000 and in_delay_slot=1.
- Likely not taken:
  - Stimulus: at pc=0x40, id_br_instr=1, id_likely=1, id_cond=0.
  - Required next cycle: pc=0x44, npc=0x48, if_squash=1 for exactly 1 advancing cycle; taken_count unchanged.
- Branch in delay slot:
  - Stimulus: while in_delay_slot=1, present id_jump=1, id_ta=0x900.
  - Required: jump ignored, npc=pc+4 sequence continues, taken_count not incremented.
- Reset mid-slot / wrap:
  - Stimulus: reset while in_delay_slot=1.
  - Required next cycle: pc=RESET_PC, flags 0.
  - Stimulus: force npc=0xFFFF_FFFC and advance.
  - Required: npc=0x0000_0000.
